// File: rtl/cpu_defs.sv
// ============================================================================
// Module      : cpu_defs
// Description : Shared bus widths, arbiter defaults and grant encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_defs;

    localparam int C_ADDR_W       = 32;
    localparam int C_DATA_W       = 32;
    localparam int C_BE_W         = 4;
    localparam int C_STREAK_W     = 4;
    localparam int C_LD_BURST_MAX = 4;

    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_FETCH = 2'd1,
        GNT_LOAD  = 2'd2
    } gnt_sel_e;

    function automatic logic [C_ADDR_W-1:0] word_align(input logic [C_ADDR_W-1:0] a);
        return a & {{(C_ADDR_W-2){1'b1}}, 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/imem_arbiter_if.sv
// ============================================================================
// Module      : imem_arbiter_if
// Description : Fetch, loader and instruction-SRAM signals of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_arbiter_if;
    import cpu_defs::*;

    logic                f_req;
    logic [C_ADDR_W-1:0] f_addr;
    logic                f_kill;
    logic                f_gnt;
    logic                f_rsp_valid;
    logic [C_DATA_W-1:0] f_rsp_data;
    logic                stall_fetch;

    logic                ld_req;
    logic [C_ADDR_W-1:0] ld_addr;
    logic [C_DATA_W-1:0] ld_wdata;
    logic [C_BE_W-1:0]   ld_be;
    logic                ld_gnt;

    logic                inst_sram_en;
    logic [C_BE_W-1:0]   inst_sram_we;
    logic [C_ADDR_W-1:0] inst_sram_addr;
    logic [C_DATA_W-1:0] inst_sram_wdata;
    logic [C_DATA_W-1:0] inst_sram_rdata;

    modport slave (
        input  f_req, f_addr, f_kill, ld_req, ld_addr, ld_wdata, ld_be, inst_sram_rdata,
        output f_gnt, f_rsp_valid, f_rsp_data, stall_fetch, ld_gnt,
               inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
    );

    modport master (
        output f_req, f_addr, f_kill, ld_req, ld_addr, ld_wdata, ld_be, inst_sram_rdata,
        input  f_gnt, f_rsp_valid, f_rsp_data, stall_fetch, ld_gnt,
               inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
    );

endinterface

`default_nettype wire

// File: rtl/arb_streak_counter.sv
// ============================================================================
// Module      : arb_streak_counter
// Description : Counts consecutive loader grants taken while fetch is waiting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_streak_counter
    import cpu_defs::*;
#(
    parameter int MAX = C_LD_BURST_MAX
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic                  i_f_req,
    input  wire logic                  i_f_gnt,
    input  wire logic                  i_ld_gnt,
    output logic [C_STREAK_W-1:0]      o_streak
);

    localparam logic [C_STREAK_W-1:0] C_MAX = C_STREAK_W'(MAX);

    logic [C_STREAK_W-1:0] r_streak;

    // The streak only means something while fetch is actually waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_streak <= '0;
        end else if (i_f_gnt || !i_f_req) begin
            r_streak <= '0;
        end else if (i_ld_gnt && (r_streak < C_MAX)) begin
            r_streak <= r_streak + C_STREAK_W'(1);
        end
    end

    assign o_streak = r_streak;

endmodule

`default_nettype wire

// File: rtl/imem_arbiter.sv
// ============================================================================
// Module      : imem_arbiter
// Description : Shares one instruction SRAM port between fetch and a loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_arbiter
    import cpu_defs::*;
#(
    parameter int LD_BURST_MAX = C_LD_BURST_MAX
) (
    input  wire logic         clk,
    input  wire logic         reset,
    imem_arbiter_if.slave     bus
);

    localparam logic [C_STREAK_W-1:0] C_BURST_MAX = C_STREAK_W'(LD_BURST_MAX);

    logic [C_STREAK_W-1:0] w_streak;
    gnt_sel_e              w_sel;
    logic                  r_pend;

    // Loader has priority until it has starved fetch for LD_BURST_MAX cycles.
    always_comb begin
        w_sel = GNT_NONE;
        if (!reset) begin
            if (bus.ld_req && (!bus.f_req || (w_streak < C_BURST_MAX))) begin
                w_sel = GNT_LOAD;
            end else if (bus.f_req) begin
                w_sel = GNT_FETCH;
            end
        end
    end

    assign bus.f_gnt       = (w_sel == GNT_FETCH);
    assign bus.ld_gnt      = (w_sel == GNT_LOAD);
    assign bus.stall_fetch = bus.f_req && !bus.f_gnt && !reset;

    always_comb begin
        bus.inst_sram_en    = 1'b0;
        bus.inst_sram_we    = '0;
        bus.inst_sram_addr  = '0;
        bus.inst_sram_wdata = '0;
        case (w_sel)
            GNT_FETCH: begin
                bus.inst_sram_en   = 1'b1;
                bus.inst_sram_addr = word_align(bus.f_addr);
            end
            GNT_LOAD: begin
                bus.inst_sram_en    = 1'b1;
                bus.inst_sram_we    = bus.ld_be;
                bus.inst_sram_addr  = word_align(bus.ld_addr);
                bus.inst_sram_wdata = bus.ld_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= 1'b0;
        end else begin
            r_pend <= bus.f_gnt;
        end
    end

    // A redirect kills only the response already in flight, never a new grant.
    assign bus.f_rsp_valid = r_pend && !bus.f_kill && !reset;
    assign bus.f_rsp_data  = bus.f_rsp_valid ? bus.inst_sram_rdata : '0;

    arb_streak_counter #(
        .MAX      (LD_BURST_MAX)
    ) u_streak (
        .clk      (clk),
        .reset    (reset),
        .i_f_req  (bus.f_req),
        .i_f_gnt  (bus.f_gnt),
        .i_ld_gnt (bus.ld_gnt),
        .o_streak (w_streak)
    );

endmodule

`default_nettype wire

// File: tb/tb_imem_arbiter.sv
// ============================================================================
// Module      : tb_imem_arbiter
// Description : Directed self-checking bench for imem_arbiter with an SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_arbiter;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    imem_arbiter_if bus();

    imem_arbiter #(
        .LD_BURST_MAX (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read SRAM: word i initialises to 0x1000_0000 + i.
    logic [31:0] mem [0:127];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'h1000_0000 + 32'(i);
            bus.inst_sram_rdata <= '0;
        end else if (bus.inst_sram_en) begin
            if (bus.inst_sram_we == 4'h0) begin
                bus.inst_sram_rdata <= mem[bus.inst_sram_addr[8:2]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (bus.inst_sram_we[b])
                        mem[bus.inst_sram_addr[8:2]][b*8 +: 8] <= bus.inst_sram_wdata[b*8 +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic freq, input logic [31:0] faddr, input logic kill,
                         input logic lreq, input logic [31:0] laddr,
                         input logic [31:0] lwdata, input logic [3:0] lbe);
        bus.f_req    = freq;
        bus.f_addr   = faddr;
        bus.f_kill   = kill;
        bus.ld_req   = lreq;
        bus.ld_addr  = laddr;
        bus.ld_wdata = lwdata;
        bus.ld_be    = lbe;
        #4;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        drive(1'b1, 32'h40, 1'b0, 1'b1, 32'h40, 32'h1234_5678, 4'hF);
        step();
        // Requests are ignored while reset is high
        drive(1'b1, 32'h40, 1'b0, 1'b1, 32'h40, 32'h1234_5678, 4'hF);
        check("rst_f_gnt",  32'(bus.f_gnt), 32'h0);
        check("rst_ld_gnt", 32'(bus.ld_gnt), 32'h0);
        check("rst_stall",  32'(bus.stall_fetch), 32'h0);
        check("rst_en",     32'(bus.inst_sram_en), 32'h0);
        check("rst_valid",  32'(bus.f_rsp_valid), 32'h0);
        step();
        reset = 1'b0;

        // Loader partial write, then fetch the same word
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b0011);
        check("ld_gnt",   32'(bus.ld_gnt), 32'h1);
        check("ld_fgnt",  32'(bus.f_gnt), 32'h0);
        check("ld_we",    32'(bus.inst_sram_we), 32'h3);
        check("ld_addr",  bus.inst_sram_addr, 32'h10);
        check("ld_wdata", bus.inst_sram_wdata, 32'hDEAD_BEEF);
        step();
        drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check("f10_gnt",  32'(bus.f_gnt), 32'h1);
        check("f10_addr", bus.inst_sram_addr, 32'h10);
        step();
        idle();
        check("f10_valid", 32'(bus.f_rsp_valid), 32'h1);
        check("f10_data",  bus.f_rsp_data, 32'h1000_BEEF);
        step();

        // Unaligned fetch address
        drive(1'b1, 32'h106, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check("f106_gnt",   32'(bus.f_gnt), 32'h1);
        check("f106_addr",  bus.inst_sram_addr, 32'h104);
        check("f106_we",    32'(bus.inst_sram_we), 32'h0);
        check("f106_stall", 32'(bus.stall_fetch), 32'h0);
        step();
        idle();
        check("f106_valid", 32'(bus.f_rsp_valid), 32'h1);
        check("f106_data",  bus.f_rsp_data, 32'h1000_0041);
        check("idle_en",    32'(bus.inst_sram_en), 32'h0);
        check("idle_addr",  bus.inst_sram_addr, 32'h0);
        step();

        // Contention: 4 loader grants then 1 fetch, twice; loader writes the fetched word
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h20, 1'b0, 1'b1, 32'h20, 32'hA000_0000 + 32'(i), 4'hF);
            check($sformatf("burst_ld%0d", i),    32'(bus.ld_gnt), ((i % 5) != 4) ? 32'h1 : 32'h0);
            check($sformatf("burst_f%0d", i),     32'(bus.f_gnt), ((i % 5) == 4) ? 32'h1 : 32'h0);
            check($sformatf("burst_stall%0d", i), 32'(bus.stall_fetch), ((i % 5) != 4) ? 32'h1 : 32'h0);
            if (i == 5) begin
                check("burst_valid5", 32'(bus.f_rsp_valid), 32'h1);
                check("burst_data5",  bus.f_rsp_data, 32'hA000_0003);
            end
            step();
        end
        idle();
        check("burst_valid10", 32'(bus.f_rsp_valid), 32'h1);
        check("burst_data10",  bus.f_rsp_data, 32'hA000_0008);
        step();

        // Redirect kills the in-flight response but not the new grant
        drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check("kill_gnt0", 32'(bus.f_gnt), 32'h1);
        step();
        drive(1'b1, 32'hC, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        check("kill_valid", 32'(bus.f_rsp_valid), 32'h0);
        check("kill_data",  bus.f_rsp_data, 32'h0);
        check("kill_gnt1",  32'(bus.f_gnt), 32'h1);
        step();
        idle();
        check("post_kill_valid", 32'(bus.f_rsp_valid), 32'h1);
        check("post_kill_data",  bus.f_rsp_data, 32'h1000_0003);
        step();

        // Reset the cycle after a fetch grant
        drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check("pre_rst_gnt", 32'(bus.f_gnt), 32'h1);
        step();
        reset = 1'b1;
        drive(1'b1, 32'h4, 1'b0, 1'b1, 32'h4, 32'h5555_5555, 4'hF);
        check("inrst_valid", 32'(bus.f_rsp_valid), 32'h0);
        check("inrst_data",  bus.f_rsp_data, 32'h0);
        check("inrst_fgnt",  32'(bus.f_gnt), 32'h0);
        check("inrst_ldgnt", 32'(bus.ld_gnt), 32'h0);
        check("inrst_en",    32'(bus.inst_sram_en), 32'h0);
        check("inrst_we",    32'(bus.inst_sram_we), 32'h0);
        check("inrst_stall", 32'(bus.stall_fetch), 32'h0);
        step();
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check("postrst_valid", 32'(bus.f_rsp_valid), 32'h0);
        step();

        // Build a streak of 3, reset, then arbitration starts from a clear streak
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
            check($sformatf("pre_streak_ld%0d", i), 32'(bus.ld_gnt), 32'h1);
            step();
        end
        reset = 1'b1;
        drive(1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
            check($sformatf("fresh_ld%0d", i), 32'(bus.ld_gnt), (i < 4) ? 32'h1 : 32'h0);
            check($sformatf("fresh_f%0d", i),  32'(bus.f_gnt),  (i == 4) ? 32'h1 : 32'h0);
            step();
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
